ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares a single-port synchronous RAM between a clock-enabled CPU and a
// level-requesting DMA loader. The CPU always wins a collision; a DMA write
// is slotted into the free cycles around CPU accesses and is never issued
// twice in a row, so the loader sees its acknowledge as an isolated pulse.
//
// Parameters:
//   WP_LO, WP_HI   inclusive CPU write-protected address window
//
// Optional feature:
//   RAM_ARBITER_WP_EN  when defined, CPU writes inside [WP_LO, WP_HI] are
//                      suppressed (the read strobe is unaffected). DMA
//                      writes are never protected. When undefined, the
//                      window parameters have no effect.
//
// Ports:
//   sys_clock       only clock, rising edge
//   reset_n         asynchronous active-low reset
//   cpu_clken       one-cycle CPU clock-enable pulse (period >= 4 cycles)
//   cpu_addr        CPU address
//   cpu_dout        CPU write data
//   cpu_we          CPU write strobe
//   cpu_cs          CPU access targets RAM
//   cpu_din         registered read data returned to the CPU
//   dma_req         loader write request (level)
//   dma_addr        loader write address (held until dma_ack)
//   dma_data        loader write data (held until dma_ack)
//   dma_ack         one-cycle grant/completion pulse
//   dma_clr         synchronous clear of dma_count
//   dma_count       number of completed loader writes (wraps)
//   ram_addr        RAM address
//   ram_din         RAM write data
//   ram_dout        RAM read data, valid one cycle after the address
//   ram_rd          RAM read strobe
//   ram_wr          RAM write strobe
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter logic [15:0] WP_LO = 16'hFF00,
  parameter logic [15:0] WP_HI = 16'hFFFF
) (
  input  logic        sys_clock,
  input  logic        reset_n,
  input  logic        cpu_clken,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic        cpu_cs,
  output logic [7:0]  cpu_din,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_data,
  output logic        dma_ack,
  input  logic        dma_clr,
  output logic [15:0] dma_count,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        ram_rd,
  output logic        ram_wr
);

  // IDLE    : bus free, waiting for a CPU enable or a DMA request
  // CPU_ACC : CPU address/data on the RAM bus
  // CPU_CAP : RAM read data valid, captured into cpu_din at the end
  // DMA_WR  : loader word written and acknowledged
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    CPU_CAP = 2'd2,
    DMA_WR  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        capCs_q, capCs_d;
  logic [7:0]  cpuDin_q, cpuDin_d;
  logic [15:0] dmaCount_q, dmaCount_d;
  logic        cpuWrProtected;

  // Write-protection decode for the CPU address. Only meaningful in CPU_ACC.
`ifdef RAM_ARBITER_WP_EN
  assign cpuWrProtected = (cpu_addr >= WP_LO) && (cpu_addr <= WP_HI);
`else
  // Window parameters are intentionally inert in this build; folding them
  // into an unused net keeps them referenced without affecting behaviour.
  logic unusedWpWindow;
  assign unusedWpWindow = ^{WP_LO, WP_HI};
  assign cpuWrProtected = 1'b0;
`endif

  // Next-state logic. The CPU is only considered when the bus is free
  // (IDLE) or just released by a DMA write, which is what gives the CPU
  // priority. Leaving DMA_WR never re-enters DMA_WR directly, so a held
  // request is serviced at most every other cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_clken) begin
          state_d = CPU_ACC;
        end else if (dma_req) begin
          state_d = DMA_WR;
        end else begin
          state_d = IDLE;
        end
      end
      CPU_ACC: begin
        state_d = CPU_CAP;
      end
      CPU_CAP: begin
        if (dma_req) begin
          state_d = DMA_WR;
        end else begin
          state_d = IDLE;
        end
      end
      DMA_WR: begin
        if (cpu_clken) begin
          state_d = CPU_ACC;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM bus mux, decoded from the registered state only. Outside the two
  // active states the CPU address/data are passed through with both strobes
  // low, so an asynchronous reset (state forced to IDLE) drops the strobes
  // and the acknowledge immediately.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_rd   = 1'b0;
    ram_wr   = 1'b0;
    dma_ack  = 1'b0;
    case (state_q)
      CPU_ACC: begin
        ram_rd = cpu_cs;
        ram_wr = cpu_cs & cpu_we & ~cpuWrProtected;
      end
      DMA_WR: begin
        ram_addr = dma_addr;
        ram_din  = dma_data;
        ram_wr   = 1'b1;
        dma_ack  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath next values. capCs remembers whether the CPU access actually
  // selected RAM, so the capture cycle only updates cpu_din for real reads.
  // dma_clr wins over a coincident DMA completion.
  always_comb begin
    capCs_d    = capCs_q;
    cpuDin_d   = cpuDin_q;
    dmaCount_d = dmaCount_q;
    if (state_q == CPU_ACC) begin
      capCs_d = cpu_cs;
    end
    if ((state_q == CPU_CAP) && capCs_q) begin
      cpuDin_d = ram_dout;
    end
    if (dma_clr) begin
      dmaCount_d = 16'h0000;
    end else if (state_q == DMA_WR) begin
      dmaCount_d = dmaCount_q + 16'd1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      capCs_q    <= 1'b0;
      cpuDin_q   <= 8'h00;
      dmaCount_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      capCs_q    <= capCs_d;
      cpuDin_q   <= cpuDin_d;
      dmaCount_q <= dmaCount_d;
    end
  end

  assign cpu_din   = cpuDin_q;
  assign dma_count = dmaCount_q;

endmodule
